// File: rtl/tile_pkg.sv
// tile_pkg: shared types and helpers for the 3x3 sliding-tile puzzle.
//   dir_t            2-bit move code (LEFT/RIGHT/UP/DOWN)
//   loc_t            4-bit space position {row[1:0], col[1:0]}
//   SPACE_LOC_RESET  bottom-right corner, matching the core's reset
//   move_legal()     1 if moving the space in direction d stays on the board
//   move_apply()     space position after a legal move
package tile_pkg;

   typedef logic [1:0] dir_t;
   typedef logic [3:0] loc_t;

   localparam dir_t LEFT  = 2'b00;
   localparam dir_t RIGHT = 2'b01;
   localparam dir_t UP    = 2'b10;
   localparam dir_t DOWN  = 2'b11;

   localparam loc_t SPACE_LOC_RESET = 4'b1010;

   function automatic logic move_legal(loc_t loc, dir_t d);
      logic [1:0] row;
      logic [1:0] col;
      logic       ok;
      row = loc[3:2];
      col = loc[1:0];
      case (d)
         LEFT:    ok = (col != 2'd0);
         RIGHT:   ok = (col <  2'd2);
         UP:      ok = (row != 2'd0);
         default: ok = (row <  2'd2);
      endcase
      return ok;
   endfunction

   // Caller guarantees legality, so no clamping is needed here.
   function automatic loc_t move_apply(loc_t loc, dir_t d);
      logic [1:0] row;
      logic [1:0] col;
      row = loc[3:2];
      col = loc[1:0];
      case (d)
         LEFT:    col = col - 2'd1;
         RIGHT:   col = col + 2'd1;
         UP:      row = row - 2'd1;
         default: row = row + 2'd1;
      endcase
      return {row, col};
   endfunction

endpackage

// File: rtl/move_fifo.sv
// move_fifo: DEPTH x 2-bit circular FIFO of move commands.
//   clk, reset   clock, async active-high reset
//   i_push/i_din write request and data (ignored when full)
//   i_pop        read request (ignored when empty)
//   o_head       entry at the read pointer
//   o_full       DEPTH entries held
//   o_empty      no entries held
// No bypass: a word written on an edge is visible at o_head only afterwards.
module move_fifo
   import tile_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic i_push,
   input  dir_t i_din,
   input  logic i_pop,
   output dir_t o_head,
   output logic o_full,
   output logic o_empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   dir_t          r_mem [DEPTH];
   logic [AW-1:0] r_wr;
   logic [AW-1:0] r_rd;
   logic [AW:0]   r_count;
   logic          w_push;
   logic          w_pop;

   assign o_full  = (r_count == FULL_CNT);
   assign o_empty = (r_count == '0);
   assign w_push  = i_push & ~o_full;
   assign w_pop   = i_pop  & ~o_empty;
   assign o_head  = r_mem[r_rd];

   // Storage needs no reset: count gates every read.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr] <= i_din;
   end

   // Pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wr <= r_wr + AW'(1);
         if (w_pop)  r_rd <= r_rd + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/move_sequencer.sv
// move_sequencer: buffers host move commands and issues at most one legal
// move per cycle to the puzzle core, tracking the space position in a shadow
// register so moves that would leave the board are dropped and counted.
//   clk, reset          clock, async active-high reset
//   in_dir/in_valid     move request; accepted when in_ready
//   in_ready            FIFO not full
//   hold                stall issue (FIFO still fills)
//   dir/dir_valid       registered move to the core
//   space_loc           shadow space position {row,col}
//   move_count          legal moves issued (saturating)
//   drop_count          illegal moves discarded (saturating)
//   empty               FIFO empty
module move_sequencer
   import tile_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       in_dir,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             hold,
   output logic [1:0]       dir,
   output logic             dir_valid,
   output logic [3:0]       space_loc,
   output logic [CNT_W-1:0] move_count,
   output logic [CNT_W-1:0] drop_count,
   output logic             empty
);

   dir_t             w_head;
   logic             w_full;
   logic             w_empty;
   logic             w_pop;
   logic             w_legal;

   dir_t             r_dir;
   logic             r_dir_valid;
   loc_t             r_space;
   logic [CNT_W-1:0] r_move_count;
   logic [CNT_W-1:0] r_drop_count;

   assign in_ready = ~w_full;
   assign w_pop    = ~w_empty & ~hold;
   assign w_legal  = move_legal(r_space, w_head);

   move_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (in_valid),
      .i_din   (in_dir),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_dir        <= LEFT;
         r_dir_valid  <= 1'b0;
         r_space      <= SPACE_LOC_RESET;
         r_move_count <= '0;
         r_drop_count <= '0;
      end else begin
         // dir_valid is a one-cycle strobe; dir keeps the last legal move.
         r_dir_valid <= 1'b0;
         if (w_pop) begin
            if (w_legal) begin
               r_dir       <= w_head;
               r_dir_valid <= 1'b1;
               r_space     <= move_apply(r_space, w_head);
               if (r_move_count != '1) r_move_count <= r_move_count + CNT_W'(1);
            end else begin
               if (r_drop_count != '1) r_drop_count <= r_drop_count + CNT_W'(1);
            end
         end
      end
   end

   assign dir        = r_dir;
   assign dir_valid  = r_dir_valid;
   assign space_loc  = r_space;
   assign move_count = r_move_count;
   assign drop_count = r_drop_count;
   assign empty      = w_empty;

endmodule
